// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rx_fifo                                                     |
// | Brief   : UART receiver with configurable frame format, per-byte error     |
// |           flags and a show-ahead FIFO on a valid/ready output.             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module uart_rx_fifo #(
    parameter int CLK_PER_BIT = 434,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    output logic [DATA_BITS-1:0]        data,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        valid,
    input  logic                        ready,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int c_CNT_W = $clog2(CLK_PER_BIT);
    localparam int c_AW    = $clog2(FIFO_DEPTH);
    localparam int c_EW    = DATA_BITS + 2;

    localparam logic [c_CNT_W-1:0] c_HALF_M1   = c_CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_M1    = c_CNT_W'(CLK_PER_BIT - 1);
    localparam logic [3:0]         c_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]         c_LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [c_AW:0]      c_DEPTH     = (c_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state, w_state_next;
    logic                 r_sync1, r_rxs, r_rxs_d;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr, r_ferr;
    logic                 r_push;
    logic [c_EW-1:0]      r_push_entry;

    logic w_edge, w_cnt_clr, w_shift_en, w_par_en, w_stop_en, w_push_req, w_frame_start;
    logic w_tick_half, w_tick_bit, w_par_bad;

    assign w_edge      = r_rxs_d & ~r_rxs;
    assign w_tick_half = (r_cnt == c_HALF_M1);
    assign w_tick_bit  = (r_cnt == c_BIT_M1);
    // Odd parity wants the data+parity XOR to be 1, even parity wants 0.
    assign w_par_bad   = (PARITY == 1) ? ~(^r_shift ^ r_rxs) : (^r_shift ^ r_rxs);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rxs   <= r_sync1;
            r_rxs_d <= r_rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_clr     = 1'b0;
        w_shift_en    = 1'b0;
        w_par_en      = 1'b0;
        w_stop_en     = 1'b0;
        w_push_req    = 1'b0;
        w_frame_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (w_edge) begin
                    w_state_next  = S_START;
                    w_frame_start = 1'b1;
                end
            end
            S_START: begin
                if (w_tick_half) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = r_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick_bit) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit == c_LAST_DATA)
                        w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_tick_bit) begin
                    w_cnt_clr    = 1'b1;
                    w_par_en     = 1'b1;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick_bit) begin
                    w_cnt_clr = 1'b1;
                    w_stop_en = 1'b1;
                    if (r_bit == c_LAST_STOP) begin
                        w_push_req   = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bit index restarts on every state change, so it counts data and stop bits alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_bit  <= '0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_push <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            r_bit  <= (w_state_next != r_state) ? '0 : r_bit + 4'(w_shift_en | w_stop_en);
            r_push <= w_push_req;
            if (w_frame_start) begin
                r_perr <= 1'b0;
                r_ferr <= 1'b0;
            end else begin
                if (w_par_en)  r_perr <= w_par_bad;
                if (w_stop_en && !r_rxs) r_ferr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_shift_en) r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
        if (w_push_req) r_push_entry <= {r_perr, r_ferr | ~r_rxs, r_shift};
    end

    logic [c_EW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wptr, r_rptr;
    logic [c_AW:0]   r_count;
    logic            r_overrun;
    logic            w_pop, w_push_ok;
    logic [c_EW-1:0] w_head;

    assign valid     = (r_count != '0);
    assign w_pop     = valid & ready;
    // A pop in the same cycle frees a slot even when full.
    assign w_push_ok = r_push & ((r_count < c_DEPTH) | w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= r_push_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_push & ~w_push_ok;
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head     = r_mem[r_rptr];
    assign data       = valid ? w_head[DATA_BITS-1:0] : '0;
    assign frame_err  = valid & w_head[DATA_BITS];
    assign parity_err = valid & w_head[DATA_BITS+1];
    assign overrun    = r_overrun;
    assign count      = r_count;

endmodule
`default_nettype wire
